ddr2_traffic_gen: RTL and testbench
===================================

# ddr2_traffic_gen

Parametrised write/read-back traffic generator and checker that drives the DDR2 controller user port after initialisation. On `start` it writes `NUM_WORDS` words of a selectable data pattern to consecutive addresses, reads them back, and compares each returned word against a regenerated expected pattern. It reports pass/fail, error count and first failing address. It replaces the fixed incrementing-data stimulus and sits between the test top level and the controller's user interface.

## Interface
- `DATA_WIDTH`, 32: user data width, 8..128.
- `ADDR_WIDTH`, 12: user word-address width.
- `NUM_WORDS`, 4096: words per pass, 1..2**ADDR_WIDTH.
- `TIMEOUT`, 1024: idle cycles without `rd_valid` in DRAIN before abort.

- `sys_clk` in 1: clock.
- `sys_rst_n` in 1: reset, asynchronous, active-low.
- `init_end` in 1: controller initialisation complete.
- `start` in 1: single-cycle run request.
- `mode` in 2: pattern; 0 increment, 1 walking-one, 2 LFSR, 3 alternating 0xA5/0x5A bytes.
- `wr_en` out 1: write request.
- `wr_addr` out ADDR_WIDTH: write word address.
- `wr_data` out DATA_WIDTH: write data.
- `wr_ready` in 1: controller accepts write this cycle.
- `rd_en` out 1: read request.
- `rd_addr` out ADDR_WIDTH: read word address.
- `rd_ready` in 1: controller accepts read this cycle.
- `rd_data` in DATA_WIDTH: returned read data.
- `rd_valid` in 1: `rd_data` valid.
- `busy` out 1: run in progress.
- `done` out 1: run finished; held until next accepted start.
- `pass` out 1: valid when `done`; 1 means zero errors and no timeout.
- `timeout` out 1: DRAIN timeout occurred.
- `err_cnt` out 16: mismatch count, saturating at 0xFFFF.
- `first_err_addr` out ADDR_WIDTH: index of first mismatching word.

## Operation
- FSM states: IDLE, WRITE, READ, DRAIN, DONE. Reset puts FSM in IDLE and drives every output to 0.
- IDLE/DONE → WRITE when `start && init_end`.
  - `mode` is latched.
  - Write/read/receive counters, `err_cnt`, `first_err_addr`, `timeout`, `done` and `pass` clear.
  - Both pattern generators reset to seed.
- `start` is ignored in all other states.
- WRITE:
  - A word transfers when `wr_en && wr_ready`. The address and pattern generator then advance.
  - After word `NUM_WORDS-1` transfers → READ.
- READ: `rd_en` with `rd_addr` equal to the issue counter. A request transfers when `rd_en && rd_ready`. After `NUM_WORDS` requests → DRAIN.
- Checker is independent of the issue side:
  - Each `rd_valid` in READ or DRAIN compares `rd_data` with the expected word, then advances the receive counter and checker generator.
  - `rd_valid` in IDLE/WRITE/DONE is ignored, as is any `rd_valid` after `NUM_WORDS` words have been received.
- DRAIN → DONE when the receive count reaches `NUM_WORDS`, or when `TIMEOUT` consecutive cycles pass without `rd_valid` (sets `timeout`).
- On entering DONE: `done`=1 and `pass` = (`err_cnt`==0 && !`timeout`).
- On mismatch: `err_cnt` increments (saturating). If it was 0, `first_err_addr` captures the receive index.
- If `init_end` deasserts while `busy`: abort to IDLE, drop requests, `done` stays 0.
- Patterns, for word index i:
  - Mode 0: i zero-extended or truncated to DATA_WIDTH.
  - Mode 1: 1 << (i mod DATA_WIDTH).
  - Mode 2: 32-bit Fibonacci LFSR, taps x^32+x^22+x^2+x+1, seed 0xFFFFFFFF, stepped once per word, replicated/truncated to DATA_WIDTH.
  - Mode 3: bytes 0xA5 for even i, 0x5A for odd i.

## Timing
- `wr_en` rises the cycle after the accepting `start` edge.
- `busy` is 1 from that cycle until DONE/IDLE entry.
- A request (`wr_en`/`rd_en`, address, data) is held stable until accepted. A new word follows in the next cycle, so back-to-back transfers reach one per cycle.
- WRITE→READ: `rd_en` rises the cycle after the last write transfer. There are no idle cycles between phases besides this one.
- Compare is registered:
  - `err_cnt` and `first_err_addr` update one cycle after the `rd_valid` edge.
  - `done` asserts one cycle after the final `rd_valid`, and `pass` reflects that final compare.
- The timeout counter resets on every `rd_valid` and counts only in DRAIN.
- Outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `ddr2_tg_pkg`:
  - Mode encodings.
  - FSM state enum.
  - LFSR polynomial and seed constants.
  - 0xA5/0x5A byte constants.
- Sub-module `tg_pattern_gen`, instantiated twice (writer and checker):
  - Inputs: `clear`, `advance`, `mode`.
  - Output: current-word `data`.
  - Holds index and LFSR state internally.

## Test plan
- Mode 0, NUM_WORDS=16, `wr_ready`/`rd_ready`=1, ideal memory model with 3-cycle read latency → 16 writes of data 0..15; `done`, `pass`=1, `err_cnt`=0.
- Mode 2, random `wr_ready`/`rd_ready` back-pressure → address/data stable while stalled; read-back matches LFSR sequence from seed 0xFFFFFFFF; `pass`=1.
- Mode 1, model flips bit 0 of word 5 and word 9 → `err_cnt`=2, `first_err_addr`=5, `pass`=0.
- Model returns only 15 of 16 words, TIMEOUT=32 → DONE 32 cycles after last `rd_valid`; `timeout`=1, `pass`=0.
- Drop `init_end` mid-WRITE, then reassert and pulse `start` → outputs return to 0 and FSM returns to IDLE; second run starts at address 0 and passes.
- Assert `sys_rst_n` low during READ → all outputs 0 asynchronously; `start` before `init_end` is ignored.

Source files
------------

// File: rtl/ddr2_tg_pkg.sv
// Shared definitions for the DDR2 write/read-back traffic generator:
// pattern mode encodings, FSM states, LFSR constants and fill bytes.
package ddr2_tg_pkg;

  typedef enum logic [1:0] {
    MODE_INC  = 2'd0,
    MODE_WALK = 2'd1,
    MODE_LFSR = 2'd2,
    MODE_ALT  = 2'd3
  } tg_mode_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } tg_state_e;

  // x^32 + x^22 + x^2 + x + 1 -> feedback from bits 31, 21, 1, 0
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'hFFFF_FFFF;

  localparam logic [7:0] BYTE_EVEN = 8'hA5;
  localparam logic [7:0] BYTE_ODD  = 8'h5A;

  // One Fibonacci step: shift left, feedback enters at bit 0.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/tg_pattern_gen.sv
// Data pattern generator: presents the word for the current index and
// steps to the next word on advance. Used once for the writer and once
// for the read-back checker so both regenerate the same sequence.
module tg_pattern_gen
  import ddr2_tg_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  clear,
  input  logic                  advance,
  input  tg_mode_e              mode,
  output logic [DATA_WIDTH-1:0] data
);

  localparam int LFSR_REPS = (DATA_WIDTH + 31) / 32;
  localparam int BYTE_REPS = (DATA_WIDTH + 7) / 8;
  localparam logic [DATA_WIDTH-1:0] WALK_INIT = DATA_WIDTH'(1);

  logic [DATA_WIDTH-1:0]   idx_q;
  logic [DATA_WIDTH-1:0]   walk_q;
  logic [31:0]             lfsr_q;
  logic [32*LFSR_REPS-1:0] lfsr_rep;
  logic [8*BYTE_REPS-1:0]  alt_rep;

  assign lfsr_rep = {LFSR_REPS{lfsr_q}};
  assign alt_rep  = idx_q[0] ? {BYTE_REPS{BYTE_ODD}} : {BYTE_REPS{BYTE_EVEN}};

  // Index, rotating one-hot and LFSR state; all return to seed on clear.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      idx_q  <= '0;
      walk_q <= WALK_INIT;
      lfsr_q <= LFSR_SEED;
    end else if (clear) begin
      idx_q  <= '0;
      walk_q <= WALK_INIT;
      lfsr_q <= LFSR_SEED;
    end else if (advance) begin
      idx_q  <= idx_q + DATA_WIDTH'(1);
      walk_q <= {walk_q[DATA_WIDTH-2:0], walk_q[DATA_WIDTH-1]};
      lfsr_q <= lfsr_step(lfsr_q);
    end
  end

  // Select the current word for the latched mode.
  // NOTE: data gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    data = '0;
    case (mode)
      MODE_INC:  data = idx_q;
      MODE_WALK: data = walk_q;
      MODE_LFSR: data = lfsr_rep[DATA_WIDTH-1:0];
      MODE_ALT:  data = alt_rep[DATA_WIDTH-1:0];
      default:   data = '0;
    endcase
  end

endmodule

// File: rtl/ddr2_traffic_gen.sv
// DDR2 user-port traffic generator: writes NUM_WORDS pattern words to
// consecutive addresses, reads them back, and checks each returned word
// against a regenerated copy of the pattern.
module ddr2_traffic_gen
  import ddr2_tg_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_WORDS  = 4096,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  init_end,
  input  logic                  start,
  input  logic [1:0]            mode,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_ready,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_ready,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [15:0]           err_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

  // Counters carry one extra bit so a full 2**ADDR_WIDTH pass is countable.
  localparam int CW = ADDR_WIDTH + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_WORDS - 1);
  localparam logic [CW-1:0] ALL_IDX  = CW'(NUM_WORDS);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  tg_state_e             state_q, state_d;
  tg_mode_e              mode_q;
  logic [CW-1:0]         iss_cnt_q;
  logic [CW-1:0]         rcv_cnt_q;
  logic [TW-1:0]         to_cnt_q;
  logic [DATA_WIDTH-1:0] chk_data;

  logic go, abort, in_run, wr_fire, rd_fire;
  logic rcv_ok, mismatch, rcv_all, timed_out, finish;

  assign in_run    = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
  assign go        = ((state_q == S_IDLE) || (state_q == S_DONE)) && start && init_end;
  assign abort     = in_run && !init_end;
  assign wr_fire   = (state_q == S_WRITE) && wr_ready;
  assign rd_fire   = (state_q == S_READ) && rd_ready;
  assign rcv_ok    = rd_valid && ((state_q == S_READ) || (state_q == S_DRAIN))
                     && (rcv_cnt_q != ALL_IDX);
  assign mismatch  = rcv_ok && (rd_data != chk_data);
  assign rcv_all   = (rcv_cnt_q == ALL_IDX) || (rcv_ok && (rcv_cnt_q == LAST_IDX));
  assign timed_out = !rcv_all && !rd_valid && (to_cnt_q == TO_LAST);
  assign finish    = (state_q == S_DRAIN) && (state_d == S_DONE);

  assign wr_addr = iss_cnt_q[ADDR_WIDTH-1:0];
  assign rd_addr = iss_cnt_q[ADDR_WIDTH-1:0];

  tg_pattern_gen #(.DATA_WIDTH(DATA_WIDTH)) u_wr_gen (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clear     (go || abort),
    .advance   (wr_fire),
    .mode      (mode_q),
    .data      (wr_data)
  );

  tg_pattern_gen #(.DATA_WIDTH(DATA_WIDTH)) u_chk_gen (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clear     (go || abort),
    .advance   (rcv_ok),
    .mode      (mode_q),
    .data      (chk_data)
  );

  // Next-state logic; loss of init_end during a run always wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (go) state_d = S_WRITE;
      S_WRITE: begin
        if (!init_end)                               state_d = S_IDLE;
        else if (wr_ready && iss_cnt_q == LAST_IDX)  state_d = S_READ;
      end
      S_READ: begin
        if (!init_end)                               state_d = S_IDLE;
        else if (rd_ready && iss_cnt_q == LAST_IDX)  state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!init_end)                  state_d = S_IDLE;
        else if (rcv_all || timed_out)  state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register plus request/busy flags registered from the next state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_en   <= (state_d == S_WRITE);
      rd_en   <= (state_d == S_READ);
      busy    <= (state_d == S_WRITE) || (state_d == S_READ) || (state_d == S_DRAIN);
    end
  end

  // Issue/receive counters, drain watchdog and registered compare results.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_q         <= MODE_INC;
      iss_cnt_q      <= '0;
      rcv_cnt_q      <= '0;
      to_cnt_q       <= '0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      timeout        <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else if (abort || go) begin
      mode_q         <= go ? tg_mode_e'(mode) : MODE_INC;
      iss_cnt_q      <= '0;
      rcv_cnt_q      <= '0;
      to_cnt_q       <= '0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      timeout        <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else begin
      // The issue counter wraps to 0 after the last write so reads restart at 0.
      if (wr_fire)
        iss_cnt_q <= (iss_cnt_q == LAST_IDX) ? '0 : iss_cnt_q + CW'(1);
      else if (rd_fire)
        iss_cnt_q <= iss_cnt_q + CW'(1);

      if (rcv_ok)
        rcv_cnt_q <= rcv_cnt_q + CW'(1);

      if (mismatch) begin
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        if (err_cnt == 16'd0)    first_err_addr <= rcv_cnt_q[ADDR_WIDTH-1:0];
      end

      if (rd_valid)
        to_cnt_q <= '0;
      else if (state_q == S_DRAIN)
        to_cnt_q <= to_cnt_q + TW'(1);

      // Pass must include the compare happening on this same edge.
      if (finish) begin
        done    <= 1'b1;
        timeout <= timed_out;
        pass    <= !timed_out && (err_cnt == 16'd0) && !mismatch;
      end
    end
  end

endmodule

// File: tb/tb_ddr2_traffic_gen.sv
// Directed bench for ddr2_traffic_gen with a small memory model
// (3-edge read latency, optional back-pressure, bit-flip and drop faults).
module tb_ddr2_traffic_gen;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int NW = 16;
  localparam int TO = 32;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n, init_end, start;
  logic [1:0]    mode;
  logic          wr_en, wr_ready, rd_en, rd_ready, rd_valid;
  logic [AW-1:0] wr_addr, rd_addr, first_err_addr;
  logic [DW-1:0] wr_data, rd_data;
  logic          busy, done, pass, timeout;
  logic [15:0]   err_cnt;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // Memory-model controls and observations
  logic [1:0]    tb_mode = 2'd0;
  bit            bp_en = 0, flip_en = 0, drop_en = 0;
  int            exp_wr_idx = 0, exp_rd_idx = 0;
  int            last_wr_cyc = 0, first_rd_cyc = -1, last_rdv_edge = 0, done_cyc = 0;
  logic [DW-1:0] mem [NW];

  ddr2_traffic_gen #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WORDS(NW), .TIMEOUT(TO)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_end(init_end), .start(start),
    .mode(mode), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .rd_en(rd_en), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .err_cnt(err_cnt), .first_err_addr(first_err_addr)
  );

  initial forever #5 sys_clk = ~sys_clk;
  initial forever begin @(posedge sys_clk); cyc++; end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected write word i for each mode.
  function automatic logic [DW-1:0] pat(input logic [1:0] m, input int i);
    logic [31:0] s;
    s = 32'hFFFF_FFFF;
    case (m)
      2'd0: return DW'(i);
      2'd1: return DW'(1) << (i % DW);
      2'd2: begin
        for (int k = 0; k < i; k++) s = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
        return s;
      end
      default: return (i % 2 == 0) ? 32'hA5A5_A5A5 : 32'h5A5A_5A5A;
    endcase
  endfunction

  // Memory model: checks request order and stall stability, returns data.
  initial begin : mem_model
    bit            rf, wstall, rstall;
    int            ra;
    logic [AW-1:0] ws_addr, rs_addr;
    logic [DW-1:0] ws_data;
    bit            p_v[2];
    int            p_a[2];
    wstall = 0; rstall = 0; ra = 0; ws_addr = '0; rs_addr = '0; ws_data = '0;
    p_v[0] = 0; p_v[1] = 0; p_a[0] = 0; p_a[1] = 0;
    for (int k = 0; k < NW; k++) mem[k] = '0;
    wr_ready = 1'b1; rd_ready = 1'b1; rd_valid = 1'b0; rd_data = '0;
    forever begin
      @(negedge sys_clk);
      rf = 0;
      if (sys_rst_n && init_end) begin
        if (wstall) begin
          check("wr_hold_en", wr_en, 1);
          check("wr_hold_addr", wr_addr, ws_addr);
          check("wr_hold_data", wr_data, ws_data);
        end
        if (rstall) begin
          check("rd_hold_en", rd_en, 1);
          check("rd_hold_addr", rd_addr, rs_addr);
        end
      end
      wstall = sys_rst_n && wr_en && !wr_ready; ws_addr = wr_addr; ws_data = wr_data;
      rstall = sys_rst_n && rd_en && !rd_ready; rs_addr = rd_addr;
      if (wr_en && wr_ready) begin
        check("wr_addr", wr_addr, AW'(exp_wr_idx));
        check("wr_data", wr_data, pat(tb_mode, exp_wr_idx));
        mem[int'(wr_addr) % NW] = wr_data;
        exp_wr_idx++;
        last_wr_cyc = cyc;
      end
      if (rd_en && first_rd_cyc < 0) first_rd_cyc = cyc;
      if (rd_en && rd_ready) begin
        check("rd_addr", rd_addr, AW'(exp_rd_idx));
        rf = 1; ra = int'(rd_addr) % NW;
        exp_rd_idx++;
      end
      @(posedge sys_clk); #1;
      rd_valid = p_v[1];
      rd_data  = '0;
      if (p_v[1]) begin
        rd_data = mem[p_a[1]];
        if (flip_en && (p_a[1] == 5 || p_a[1] == 9)) rd_data[0] = ~rd_data[0];
        last_rdv_edge = cyc + 1;
      end
      p_v[1] = p_v[0]; p_a[1] = p_a[0];
      p_v[0] = rf && !(drop_en && ra == NW - 1); p_a[0] = ra;
      if (!sys_rst_n) begin
        p_v[0] = 0; p_v[1] = 0; rd_valid = 1'b0; rd_data = '0;
      end
      wr_ready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      rd_ready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
    check({tag, "_first_err"}, first_err_addr, 0);
  endtask

  task automatic pulse_start(input logic [1:0] m);
    tb_mode = m; exp_wr_idx = 0; exp_rd_idx = 0; first_rd_cyc = -1;
    @(posedge sys_clk); #1;
    mode = m; start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0; mode = 2'd0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!done && k < 2000) begin @(negedge sys_clk); k++; end
    check({tag, "_done_seen"}, done, 1);
    done_cyc = cyc;
  endtask

  // Full run: start, check first request, wait for done, check phase gap.
  task automatic run(input logic [1:0] m, input string tag);
    pulse_start(m);
    @(negedge sys_clk);
    check({tag, "_busy_on"}, busy, 1);
    check({tag, "_wr_en_on"}, wr_en, 1);
    check({tag, "_first_addr"}, wr_addr, 0);
    check({tag, "_first_data"}, wr_data, pat(m, 0));
    check({tag, "_done_clr"}, done, 0);
    wait_done(tag);
    check({tag, "_busy_off"}, busy, 0);
    check({tag, "_writes"}, exp_wr_idx, NW);
    check({tag, "_reads"}, exp_rd_idx, NW);
    check({tag, "_wr_rd_gap"}, first_rd_cyc - last_wr_cyc, 1);
  endtask

  initial begin : main
    int k;
    sys_rst_n = 1'b1; init_end = 1'b0; start = 1'b0; mode = 2'd0;
    #2 sys_rst_n = 1'b0;
    #1 check_zero("reset");
    #20 sys_rst_n = 1'b1;

    // start while init_end is low must be ignored
    pulse_start(2'd0);
    @(negedge sys_clk);
    check("noinit_busy", busy, 0);
    check("noinit_wr_en", wr_en, 0);
    @(posedge sys_clk); #1 init_end = 1'b1;

    // Mode 0, no back-pressure: data 0..15, clean pass
    run(2'd0, "inc");
    check("inc_pass", pass, 1);
    check("inc_err_cnt", err_cnt, 0);
    check("inc_timeout", timeout, 0);

    // Mode 2 under random back-pressure
    bp_en = 1;
    run(2'd2, "lfsr");
    check("lfsr_word3", pat(2'd2, 3), 32'hFFFF_FFFB);
    check("lfsr_pass", pass, 1);
    check("lfsr_err_cnt", err_cnt, 0);
    bp_en = 0;

    // Mode 3 alternating bytes
    run(2'd3, "alt");
    check("alt_pass", pass, 1);

    // Mode 1 with words 5 and 9 corrupted
    flip_en = 1;
    run(2'd1, "walk");
    check("walk_err_cnt", err_cnt, 2);
    check("walk_first_err", first_err_addr, 5);
    check("walk_pass", pass, 0);
    check("walk_timeout", timeout, 0);
    flip_en = 0;

    // Last word never returned: timeout 32 cycles after final rd_valid
    drop_en = 1;
    run(2'd0, "drop");
    check("drop_timeout", timeout, 1);
    check("drop_pass", pass, 0);
    check("drop_err_cnt", err_cnt, 0);
    check("drop_latency", done_cyc - last_rdv_edge, TO);
    drop_en = 0;

    // init_end lost mid-WRITE: abort to IDLE, then a clean rerun
    pulse_start(2'd1);
    repeat (4) @(posedge sys_clk);
    #1 init_end = 1'b0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    check_zero("abort");
    @(posedge sys_clk); #1 init_end = 1'b1;
    run(2'd0, "rerun");
    check("rerun_pass", pass, 1);

    // Asynchronous reset during READ
    pulse_start(2'd0);
    k = 0;
    while (!rd_en && k < 200) begin @(negedge sys_clk); k++; end
    check("reach_read", rd_en, 1);
    #1 sys_rst_n = 1'b0;
    #1 check_zero("async_rst");
    init_end = 1'b0;
    #20 sys_rst_n = 1'b1;
    pulse_start(2'd0);
    @(negedge sys_clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_wr_en", wr_en, 0);
    check("post_rst_done", done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
